// File: rtl/gate_stim_seq.sv
// gate_stim_seq: clocked sweep of every input vector onto a 2-input gate stage.
// Define GATE_STIM_SELFCHECK_EN to count AND-gate response mismatches in err_cnt.
module gate_stim_seq #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             out1,
  output logic [WIDTH-1:0] stim,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic [ERRW-1:0]  err_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};
  state_t state, state_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [WIDTH:0] vec_cnt, vec_nxt;
  logic [WIDTH-1:0] stim_nxt;
  logic [ERRW-1:0] err_nxt;
  logic sample, last, vv_nxt, busy_nxt, done_nxt;
  assign sample = state == DRIVE && hold_cnt == 8'(HOLD - 1);
  assign last = vec_cnt == LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      vec_cnt   <= '0;
      stim      <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      vec_cnt   <= vec_nxt;
      stim      <= stim_nxt;
      vec_valid <= vv_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err_cnt   <= err_nxt;
    end
  end
  always_comb begin
    state_nxt = state == IDLE  ? (start ? DRIVE : IDLE) :
                state == DRIVE ? (sample && last ? DONE : DRIVE) : IDLE;
  end
  // Outputs are registered, so they are derived from the next-cycle counters.
  always_comb begin
    hold_nxt = state == DRIVE && !sample ? hold_cnt + 8'd1 : '0;
    vec_nxt  = state != DRIVE ? '0 : sample && !last ? vec_cnt + 1'b1 : vec_cnt;
    stim_nxt = state_nxt == DRIVE ? vec_nxt[WIDTH-1:0] : '0;
    vv_nxt   = state_nxt == DRIVE && hold_nxt == 8'(HOLD - 1);
    busy_nxt = state_nxt == DRIVE;
    done_nxt = state_nxt == DONE;
  end
`ifdef GATE_STIM_SELFCHECK_EN
  assign err_nxt = state == IDLE && start ? '0 :
                   sample && out1 != &stim && err_cnt != '1 ? err_cnt + 1'b1 : err_cnt;
`else
  logic unused_out1;
  assign unused_out1 = out1;
  assign err_nxt = '0;
`endif
endmodule

// File: tb/tb_gate_stim_seq.sv
// tb_gate_stim_seq: directed checks of sweep timing, start handling, reset and self-check.
module tb_gate_stim_seq;
  logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, force1 = 1'b0;
  logic [1:0] stim_a, stim_b;
  logic vv_a, vv_b, busy_a, busy_b, done_a, done_b, out1_a, out1_b;
  logic [7:0] err_a, err_b;
  int n_cmp = 0, n_bad = 0;
`ifdef GATE_STIM_SELFCHECK_EN
  localparam logic [7:0] FORCED_ERR = 8'd3;
`else
  localparam logic [7:0] FORCED_ERR = 8'd0;
`endif
  assign out1_a = force1 | &stim_a;
  assign out1_b = force1 | &stim_b;
  always #5 clk = ~clk;
  gate_stim_seq #(.WIDTH(2), .HOLD(4), .ERRW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .out1(out1_a), .stim(stim_a),
    .vec_valid(vv_a), .busy(busy_a), .done(done_a), .err_cnt(err_a));
  gate_stim_seq #(.WIDTH(2), .HOLD(1), .ERRW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .out1(out1_b), .stim(stim_b),
    .vec_valid(vv_b), .busy(busy_b), .done(done_b), .err_cnt(err_b));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // {stim, vec_valid, busy, done} expected in cycle c after a start in cycle 0.
  function automatic logic [4:0] model(input int c, input int hold);
    int len;
    bit act;
    len = hold * 4;
    act = c >= 1 && c <= len;
    return {act ? 2'((c - 1) / hold) : 2'd0, act && c % hold == 0, act, c == len + 1};
  endfunction
  task automatic sweep(input int p1, input int p2, input logic [7:0] err_exp);
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      start_a = c == p1 || c == p2;
      check($sformatf("a_c%0d", c), {stim_a, vv_a, busy_a, done_a}, model(c, 4));
      check($sformatf("b_c%0d", c), {stim_b, vv_b, busy_b, done_b}, model(c, 1));
      if (c == 1) check("a_err_cleared", err_a, 0);
      if (c == 5) check("b_err_done", err_b, err_exp);
      if (c == 17) check("a_err_done", err_a, err_exp);
      if (c == 20) check("a_err_held", err_a, err_exp);
      tick();
    end
    start_a = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {stim_a, vv_a, busy_a, done_a, err_a}, 0);
    check("rst_b", {stim_b, vv_b, busy_b, done_b, err_b}, 0);
    rst_n = 1'b1;
    tick();
    sweep(-1, -1, 8'd0);
    sweep(3, 17, 8'd0);
    force1 = 1'b1;
    sweep(-1, -1, FORCED_ERR);
    force1 = 1'b0;
    sweep(-1, -1, 8'd0);
    start_a = 1'b1;
    repeat (17) tick();
    check("rearm_done", done_a, 1);
    tick();
    check("rearm_idle", busy_a, 0);
    tick();
    check("rearm_busy", {stim_a, busy_a}, 3'b001);
    start_a = 1'b0;
    repeat (16) tick();
    check("rearm_done2", {busy_a, done_a}, 2'b01);
    tick();
    start_a = 1'b1;
    start_b = 1'b1;
    force1 = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (9) tick();
    check("pre_rst_stim", stim_a, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_a", {stim_a, vv_a, busy_a, done_a, err_a}, 0);
    check("midrst_b", {stim_b, vv_b, busy_b, done_b, err_b}, 0);
    #2 rst_n = 1'b1;
    force1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("post_rst_c%0d", c), {busy_a, done_a, busy_b, done_b}, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
